// File: rtl/imem_loader_pkg.sv
// Shared state encoding and sizing helpers for the instruction-memory loader.
// IMEM_LOADER_CSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

  localparam int unsigned LEN_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef IMEM_LOADER_CSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned byte_idx_width(input int unsigned data_width);
    return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word packer: byte k of a word lands in bits [8k+7:8k].
// word_valid pulses the cycle after the last byte of a kept word is accepted.
module byte_word_packer
  import imem_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [7:0]            data,
  input  logic                  accept,
  input  logic                  keep,
  output logic                  last_c,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int unsigned BPW = bytes_per_word(DATA_WIDTH);
  localparam int unsigned IW  = byte_idx_width(DATA_WIDTH);

  logic [IW-1:0]         byte_idx;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_c;

  // Word as it looks once the incoming byte is merged in.
  always_comb begin
    last_c = (byte_idx == IW'(BPW - 1));
    acc_c  = acc;
    acc_c[{byte_idx, 3'b000} +: 8] = data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx   <= '0;
      acc        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
        acc      <= '0;
      end else if (accept) begin
        acc <= acc_c;
        if (last_c) begin
          byte_idx <= '0;
          // Dropped words leave word untouched so wr_data holds.
          if (keep) begin
            word_valid <= 1'b1;
            word       <= acc_c;
          end
        end else begin
          byte_idx <= byte_idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte frame into the instruction RAM write port and
// holds the CPU via busy while loading. IMEM_LOADER_CSUM_EN enables a checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf_err,
  output logic                  csum_err,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
  localparam int unsigned WW    = ADDR_WIDTH + 1;

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_t POST_DATA = CSUM;
`else
  localparam state_t POST_DATA = DONE;
`endif

  state_t               state;
  state_t               state_nxt;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] word_idx;
  logic                 accept_c;
  logic                 clear_c;
  logic                 keep_c;
  logic                 ovf_c;
  logic                 pack_last_c;
  logic                 word_end_c;
  logic                 last_word_c;
  logic                 ready_nxt_c;

  assign accept_c    = s_valid && s_ready;
  assign clear_c     = (state == IDLE) && start;
  assign keep_c      = 32'(word_idx) < DEPTH;
  assign ovf_c       = 32'({s_data, len[7:0]}) > DEPTH;
  assign word_end_c  = accept_c && (state == DATA) && pack_last_c;
  assign last_word_c = (word_idx == len - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ready_nxt_c = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = LEN_LO;
      LEN_LO: if (accept_c) state_nxt = LEN_HI;
      LEN_HI: begin
        if (accept_c) begin
          if ({s_data, len[7:0]} == '0) state_nxt = POST_DATA;
          else                          state_nxt = DATA;
        end
      end
      DATA:   if (word_end_c && last_word_c) state_nxt = POST_DATA;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM:   if (accept_c) state_nxt = DONE;
`endif
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // s_ready follows the registered state only, never s_valid.
    case (state_nxt)
      LEN_LO, LEN_HI, DATA: ready_nxt_c = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM:                 ready_nxt_c = 1'b1;
`endif
      default:              ready_nxt_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ovf_err       <= 1'b0;
      wr_addr       <= '0;
      words_written <= '0;
      len           <= '0;
      word_idx      <= '0;
    end else begin
      s_ready <= ready_nxt_c;
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
      if (clear_c) begin
        ovf_err       <= 1'b0;
        words_written <= '0;
        word_idx      <= '0;
      end
      if (state == LEN_LO && accept_c) len[7:0] <= s_data;
      if (state == LEN_HI && accept_c) begin
        len[LEN_WIDTH-1:8] <= s_data;
        if (ovf_c) ovf_err <= 1'b1;
      end
      // Words past the RAM are consumed; wr_addr never wraps onto earlier words.
      if (word_end_c) begin
        word_idx <= word_idx + LEN_WIDTH'(1);
        if (keep_c) begin
          wr_addr       <= ADDR_WIDTH'(word_idx);
          words_written <= words_written + WW'(1);
        end
      end
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] sum;

  // Data bytes plus checksum byte must sum to zero mod 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= '0;
      csum_err <= 1'b0;
    end else begin
      if (clear_c) begin
        sum      <= '0;
        csum_err <= 1'b0;
      end else if (state == DATA && accept_c) begin
        sum <= sum + s_data;
      end
      if (state == CSUM && accept_c && 8'(sum + s_data) != 8'h00) csum_err <= 1'b1;
    end
  end
`else
  assign csum_err = 1'b0;
`endif

  byte_word_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_c),
    .data      (s_data),
    .accept    (accept_c && (state == DATA)),
    .keep      (keep_c),
    .last_c    (pack_last_c),
    .word_valid(wr_en),
    .word      (wr_data)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_WIDTH=4); checksum cases run when
// IMEM_LOADER_CSUM_EN is defined.
module tb_imem_loader;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          ovf_err;
  logic          csum_err;
  logic [AW:0]   words_written;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int          wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          acc_q[$];
  logic [7:0]  fr[$];
  logic [31:0] exp_d[$];

  imem_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .ovf_err      (ovf_err),
    .csum_err     (csum_err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) fr.push_back(w[8*k +: 8]);
  endtask

  task automatic add_csum();
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] s = 8'h00;
    for (int i = 2; i < fr.size(); i++) s = s + fr[i];
    fr.push_back(8'h00 - s);
`endif
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input bit word_end);
    int n = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check("s_ready_timeout", 64'd0, 64'd1);
      s_valid = 1'b0;
      return;
    end
    if (word_end) acc_q.push_back(cyc);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int nwords, input bit gaps);
    for (int i = 0; i < fr.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(fr[i], (i >= 2) && (i < 2 + 4 * nwords) && ((i - 2) % 4 == 3));
    end
  endtask

  task automatic start_frame();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    acc_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_writes(input int n, input bit chk_lat);
    check("wr_count", 64'(wq_addr.size()), 64'(n));
    for (int j = 0; j < n && j < wq_addr.size(); j++) begin
      check("wr_addr", 64'(wq_addr[j]), 64'(j));
      check("wr_data", 64'(wq_data[j]), 64'(exp_d[j]));
      if (chk_lat && j < acc_q.size()) check("wr_latency", 64'(wq_cyc[j]), 64'(acc_q[j] + 1));
    end
  endtask

  task automatic load_three_word();
    fr = '{8'h03, 8'h00};
    push_word(32'h12345678);
    push_word(32'hDEADBEEF);
    push_word(32'h00000001);
    add_csum();
    exp_d = '{32'h12345678, 32'hDEADBEEF, 32'h00000001};
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_ovf_err"}, 64'(ovf_err), 64'd0);
    check({tag, "_csum_err"}, 64'(csum_err), 64'd0);
    check({tag, "_words_written"}, 64'(words_written), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Three words, back-to-back bytes
    load_three_word();
    start_frame();
    check("t1_busy_start", 64'(busy), 64'd1);
    check("t1_s_ready_start", 64'(s_ready), 64'd1);
    send_frame(3, 1'b0);
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy_at_done", 64'(busy), 64'd1);
    check("t1_words_written", 64'(words_written), 64'd3);
    @(negedge clk); #1;
    check("t1_done_clear", 64'(done), 64'd0);
    check("t1_busy_clear", 64'(busy), 64'd0);
    check("t1_s_ready_idle", 64'(s_ready), 64'd0);
    check_writes(3, 1'b1);

    // Same frame with random valid gaps
    load_three_word();
    start_frame();
    send_frame(3, 1'b1);
    check("t2_done", 64'(done), 64'd1);
    check("t2_words_written", 64'(words_written), 64'd3);
    @(negedge clk); #1;
    check_writes(3, 1'b1);

    // Zero-length frame
    fr = '{8'h00, 8'h00};
    add_csum();
    start_frame();
    send_frame(0, 1'b0);
    check("t3_done", 64'(done), 64'd1);
    check("t3_words_written", 64'(words_written), 64'd0);
    @(negedge clk); #1;
    check_writes(0, 1'b0);

    // 17 words into a 16-word RAM
    fr = '{8'h11, 8'h00};
    exp_d.delete();
    for (int w = 0; w < 17; w++) begin
      push_word(32'hC0DE0000 + 32'(w));
      exp_d.push_back(32'hC0DE0000 + 32'(w));
    end
    add_csum();
    start_frame();
    send_frame(17, 1'b0);
    check("t4_done", 64'(done), 64'd1);
    check("t4_ovf_err", 64'(ovf_err), 64'd1);
    check("t4_words_written", 64'(words_written), 64'd16);
    check("t4_wr_addr_hold", 64'(wr_addr), 64'd15);
    @(negedge clk); #1;
    check_writes(16, 1'b1);

    // Reset after six data bytes
    load_three_word();
    start_frame();
    check("t5_ovf_cleared", 64'(ovf_err), 64'd0);
    for (int i = 0; i < 8; i++) send_byte(fr[i], i == 5);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("t5_reset");
    rst = 1'b0;
    s_valid = 1'b1;
    s_data = 8'hAD;
    repeat (4) @(negedge clk);
    check("t5_s_ready_low", 64'(s_ready), 64'd0);
    check("t5_busy_low", 64'(busy), 64'd0);
    s_valid = 1'b0;
    check_writes(1, 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
    // Good and bad checksum
    for (int t = 0; t < 2; t++) begin
      fr = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
      if (t == 1) fr[6] = 8'hF5;
      exp_d = '{32'h04030201};
      start_frame();
      check("t6_csum_cleared", 64'(csum_err), 64'd0);
      send_frame(1, 1'b0);
      check("t6_done", 64'(done), 64'd1);
      check("t6_csum_err", 64'(csum_err), 64'(t));
      @(negedge clk); #1;
      check_writes(1, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart of the instruction memory: takes a byte stream (for example from a UART receiver) and writes little-endian words into the instruction RAM's write port.
- Holds the CPU in reset while it is loading.
- Sits between the boot/debug serial path and the instruction memory.
- Frame format: 2-byte word count N (little-endian), then 4*N data bytes (DATA_WIDTH/8 bytes per word).

Parameters:
- ADDR_WIDTH, 10, RAM word-address width; range 4-10.
- DATA_WIDTH, 32, RAM word width; multiple of 8, range 8-256.
- LEN_WIDTH, 16, width of the frame length field; fixed to 2 header bytes.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new frame; honoured only in IDLE.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts byte.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_WIDTH  RAM word address.
- wr_data  out  DATA_WIDTH  RAM write word.
- busy  out  1  frame in progress; drives the CPU reset hold.
- done  out  1  one-cycle pulse at end of frame.
- ovf_err  out  1  sticky: N exceeded RAM depth.
- csum_err  out  1  sticky checksum mismatch (optional feature).
- words_written  out  ADDR_WIDTH+1  words committed in the current/last frame.

Behaviour:
- Single clock domain. Reset is synchronous, active-high.
- Reset state is IDLE. All outputs reset to 0, including s_ready, wr_en, wr_addr, wr_data, busy, done, ovf_err, csum_err and words_written.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM (only with the feature), DONE.
- IDLE -> LEN_LO on start. This cycle clears ovf_err, csum_err, words_written, the byte index and the word index.
- Byte transfer occurs on s_valid && s_ready. s_ready=1 exactly in LEN_LO, LEN_HI, DATA and CSUM. No combinational path from s_valid to s_ready.
- LEN_LO: the accepted byte becomes N[7:0]; go to LEN_HI.
- LEN_HI: the accepted byte becomes N[15:8].
  - N=0: go to CSUM if enabled, else DONE.
  - N>0: go to DATA.
- DATA: byte k of the current word goes to bits [8k+7:8k], k=0 first.
  - On acceptance of the last byte of a word: next cycle wr_en=1 for exactly one cycle, with wr_addr=word index and wr_data=the assembled word. Latency is 1 cycle.
  - Word index increments after each word.
  - words_written increments in the same cycle as wr_en.
  - After word N-1 is accepted: go to CSUM if enabled, else DONE.
- Capacity: if N > 2**ADDR_WIDTH, ovf_err is set in the LEN_HI->next transition.
  - Words at index >= 2**ADDR_WIDTH are consumed but never written (wr_en stays 0).
  - wr_addr never wraps, so no earlier word is overwritten.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
- busy=1 in every state except IDLE.
- start while busy is ignored.
- rst mid-frame: return to IDLE immediately. The partial word is discarded and no further wr_en is issued. Already-written RAM words are unaffected.
- wr_data and wr_addr hold their last value when wr_en=0.

Optional Feature:
- Macro: IMEM_LOADER_CSUM_EN.
- Defined:
  - CSUM state follows the data bytes and accepts one checksum byte.
  - The 8-bit sum (mod 256) of all data bytes plus the checksum byte must equal 0x00; otherwise csum_err is set (sticky until next start). Header bytes are excluded from the sum.
  - Then go to DONE.
- Not defined: no CSUM state and no sum register; csum_err is tied to 0.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum;
  - LEN_WIDTH=16;
  - BYTES_PER_WORD = DATA_WIDTH/8, with index width $clog2(BYTES_PER_WORD) (minimum 1).
- One sub-module, byte_word_packer:
  - byte in with accept strobe, plus a clear input;
  - word out with a one-cycle word_valid;
  - owns the byte index and shift register.

Test Plan:
- Three-word frame: start; bytes 03 00 | 78 56 34 12 | EF BE AD DE | 01 00 00 00, s_valid held high.
  - Expect wr_en pulses with (0, 0x12345678), (1, 0xDEADBEEF), (2, 0x00000001).
  - done one cycle after the final byte; words_written=3; busy high from start until done.
- Backpressure/gaps: same frame with s_valid toggled randomly.
  - Identical writes.
  - wr_en exactly 1 cycle after each 4th accepted byte.
- Zero length: start; bytes 00 00.
  - No wr_en; done pulse; words_written=0.
- Overflow: ADDR_WIDTH=4; header 11 00 (N=17), 68 data bytes.
  - 16 writes to addresses 0-15; word 17 not written.
  - ovf_err=1; done asserted.
- Reset mid-frame: rst asserted after 6 data bytes of the first case.
  - One write at address 0 only.
  - All outputs 0 the next cycle; s_ready=0 until the next start.
- IMEM_LOADER_CSUM_EN: frame 01 00 | 01 02 03 04 | F6.
  - csum_err=0.
  - Repeat with a final byte of F5: csum_err=1, done still pulses.
